// File: rtl/mpc_pipe_arbiter.sv
// -----------------------------------------------------------------------------
// mpc_pipe_arbiter
//   Single-issue arbiter in front of the MPC cache tag/data pipeline. Three
//   requesters (refill RF, write-back WB, core CORE) compete for a one-entry
//   output register that feeds the pipeline. Each request is translated into
//   an internal pipeline command. A credit counter bounds how many issued ops
//   may be in flight, and an age counter keeps the core from starving behind
//   the higher-priority refill/write-back traffic.
//
// Ports
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   core_valid_i/ready_o/op/addr/id core request (LOAD/STORE) handshake
//   wb_valid_i/ready_o/addr/id      write-back request handshake
//   rf_valid_i/ready_o/op/addr/id   refill request handshake
//   pipe_valid_o/ready_i            issue slot handshake to the pipeline
//   pipe_op_o/addr_o/id_o/src_o     issued command, address, id, source
//   pipe_retire_i                   one in-flight op has completed
//   credits_o                       free credits
//   err_o                           sticky protocol error
// -----------------------------------------------------------------------------
module mpc_pipe_arbiter #(
    parameter int ADDR_W     = 49,
    parameter int ID_W       = 4,
    parameter int CREDITS    = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         core_valid_i,
    output logic                         core_ready_o,
    input  logic [2:0]                   core_op_i,
    input  logic [ADDR_W-1:0]            core_addr_i,
    input  logic [ID_W-1:0]              core_id_i,
    input  logic                         wb_valid_i,
    output logic                         wb_ready_o,
    input  logic [ADDR_W-1:0]            wb_addr_i,
    input  logic [ID_W-1:0]              wb_id_i,
    input  logic                         rf_valid_i,
    output logic                         rf_ready_o,
    input  logic [2:0]                   rf_op_i,
    input  logic [ADDR_W-1:0]            rf_addr_i,
    input  logic [ID_W-1:0]              rf_id_i,
    output logic                         pipe_valid_o,
    input  logic                         pipe_ready_i,
    output logic [2:0]                   pipe_op_o,
    output logic [ADDR_W-1:0]            pipe_addr_o,
    output logic [ID_W-1:0]              pipe_id_o,
    output logic [1:0]                   pipe_src_o,
    input  logic                         pipe_retire_i,
    output logic [$clog2(CREDITS+1)-1:0] credits_o,
    output logic                         err_o
);

    localparam int CRED_W = $clog2(CREDITS + 1);
    localparam int STV_W  = $clog2(STARVE_MAX + 1);

    // Core-side command encoding (mpc_command_e)
    localparam logic [2:0] MPC_OP_LOAD  = 3'd0;
    localparam logic [2:0] MPC_OP_STORE = 3'd1;

    // Pipeline command encoding (internal_command_e)
    typedef enum logic [2:0] {
        CACHE_OP_LOAD         = 3'd0,
        CACHE_OP_STORE        = 3'd1,
        CACHE_OP_WB           = 3'd4,
        CACHE_OP_LOAD_REFILL  = 3'd5,
        CACHE_OP_STORE_REFILL = 3'd6
    } internal_command_e;

    localparam logic [1:0] SRC_CORE = 2'd0;
    localparam logic [1:0] SRC_WB   = 2'd1;
    localparam logic [1:0] SRC_RF   = 2'd2;

    logic [STV_W-1:0]  starve_cnt;
    logic              slot_free;
    logic              force_core;
    logic              gnt_core;
    logic              gnt_wb;
    logic              gnt_rf;
    logic              any_gnt;
    logic [2:0]        nxt_op;
    logic [ADDR_W-1:0] nxt_addr;
    logic [ID_W-1:0]   nxt_id;
    logic [1:0]        nxt_src;
    logic              op_err;
    logic              retire_bad;
    logic              retire_ok;

    // Credits are sampled from the register, so a retire in a zero-credit
    // cycle only frees the slot for the following cycle.
    assign slot_free  = (!pipe_valid_o || pipe_ready_i) && (credits_o != '0) && !rst_i;
    assign force_core = core_valid_i && (starve_cnt == STV_W'(STARVE_MAX));

    always_comb begin
        gnt_core = 1'b0;
        gnt_wb   = 1'b0;
        gnt_rf   = 1'b0;
        if (slot_free) begin
            if (force_core)      gnt_core = 1'b1;
            else if (rf_valid_i) gnt_rf   = 1'b1;
            else if (wb_valid_i) gnt_wb   = 1'b1;
            else if (core_valid_i) gnt_core = 1'b1;
        end
    end

    assign core_ready_o = gnt_core;
    assign wb_ready_o   = gnt_wb;
    assign rf_ready_o   = gnt_rf;
    assign any_gnt      = gnt_core || gnt_wb || gnt_rf;

    // Payload selection and command mapping for the granted source
    always_comb begin
        nxt_op   = CACHE_OP_LOAD;
        nxt_addr = core_addr_i;
        nxt_id   = core_id_i;
        nxt_src  = SRC_CORE;
        op_err   = 1'b0;
        if (gnt_rf) begin
            nxt_op   = rf_op_i;
            nxt_addr = rf_addr_i;
            nxt_id   = rf_id_i;
            nxt_src  = SRC_RF;
            op_err   = (rf_op_i != CACHE_OP_LOAD_REFILL) && (rf_op_i != CACHE_OP_STORE_REFILL);
        end else if (gnt_wb) begin
            nxt_op   = CACHE_OP_WB;
            nxt_addr = wb_addr_i;
            nxt_id   = wb_id_i;
            nxt_src  = SRC_WB;
        end else if (gnt_core) begin
            case (core_op_i)
                MPC_OP_LOAD:  nxt_op = CACHE_OP_LOAD;
                MPC_OP_STORE: nxt_op = CACHE_OP_STORE;
                default: begin
                    // Illegal core op still consumes its grant so the
                    // requester is not stuck; it is flagged instead.
                    nxt_op = CACHE_OP_LOAD;
                    op_err = 1'b1;
                end
            endcase
        end
    end

    // A retire with every credit already free has nothing to return.
    assign retire_bad = pipe_retire_i && (credits_o == CRED_W'(CREDITS));
    assign retire_ok  = pipe_retire_i && !retire_bad;

    // Issue register stage: payload captured on the grant edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_valid_o <= 1'b0;
            pipe_op_o    <= '0;
            pipe_addr_o  <= '0;
            pipe_id_o    <= '0;
            pipe_src_o   <= '0;
            credits_o    <= CRED_W'(CREDITS);
            starve_cnt   <= '0;
            err_o        <= 1'b0;
        end else begin
            if (any_gnt) begin
                pipe_valid_o <= 1'b1;
                pipe_op_o    <= nxt_op;
                pipe_addr_o  <= nxt_addr;
                pipe_id_o    <= nxt_id;
                pipe_src_o   <= nxt_src;
            end else if (pipe_ready_i) begin
                pipe_valid_o <= 1'b0;
            end

            case ({any_gnt, retire_ok})
                2'b10:   credits_o <= credits_o - CRED_W'(1);
                2'b01:   credits_o <= credits_o + CRED_W'(1);
                default: credits_o <= credits_o;
            endcase

            if (core_valid_i && !core_ready_o) begin
                if (starve_cnt != STV_W'(STARVE_MAX))
                    starve_cnt <= starve_cnt + STV_W'(1);
            end else begin
                starve_cnt <= '0;
            end

            if ((any_gnt && op_err) || retire_bad)
                err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mpc_pipe_arbiter.sv
module tb_mpc_pipe_arbiter;

    localparam int ADDR_W = 49;
    localparam int ID_W   = 4;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              core_valid_i;
    logic              core_ready_o;
    logic [2:0]        core_op_i;
    logic [ADDR_W-1:0] core_addr_i;
    logic [ID_W-1:0]   core_id_i;
    logic              wb_valid_i;
    logic              wb_ready_o;
    logic [ADDR_W-1:0] wb_addr_i;
    logic [ID_W-1:0]   wb_id_i;
    logic              rf_valid_i;
    logic              rf_ready_o;
    logic [2:0]        rf_op_i;
    logic [ADDR_W-1:0] rf_addr_i;
    logic [ID_W-1:0]   rf_id_i;
    logic              pipe_valid_o;
    logic              pipe_ready_i;
    logic [2:0]        pipe_op_o;
    logic [ADDR_W-1:0] pipe_addr_o;
    logic [ID_W-1:0]   pipe_id_o;
    logic [1:0]        pipe_src_o;
    logic              pipe_retire_i;
    logic [2:0]        credits_o;
    logic              err_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mpc_pipe_arbiter #(
        .ADDR_W(ADDR_W), .ID_W(ID_W), .CREDITS(4), .STARVE_MAX(8)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .core_valid_i(core_valid_i), .core_ready_o(core_ready_o), .core_op_i(core_op_i),
        .core_addr_i(core_addr_i), .core_id_i(core_id_i),
        .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o), .wb_addr_i(wb_addr_i), .wb_id_i(wb_id_i),
        .rf_valid_i(rf_valid_i), .rf_ready_o(rf_ready_o), .rf_op_i(rf_op_i),
        .rf_addr_i(rf_addr_i), .rf_id_i(rf_id_i),
        .pipe_valid_o(pipe_valid_o), .pipe_ready_i(pipe_ready_i), .pipe_op_o(pipe_op_o),
        .pipe_addr_o(pipe_addr_o), .pipe_id_o(pipe_id_o), .pipe_src_o(pipe_src_o),
        .pipe_retire_i(pipe_retire_i), .credits_o(credits_o), .err_o(err_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        core_valid_i  = 1'b0; core_op_i = 3'd0; core_addr_i = '0; core_id_i = '0;
        wb_valid_i    = 1'b0; wb_addr_i = '0; wb_id_i = '0;
        rf_valid_i    = 1'b0; rf_op_i = 3'd5; rf_addr_i = '0; rf_id_i = '0;
        pipe_ready_i  = 1'b1;
        pipe_retire_i = 1'b0;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        clear_inputs();
        repeat (2) tick();
        rst_i = 1'b0;
    endtask

    // Return all outstanding credits with idle requesters.
    task automatic drain();
        for (int i = 0; i < 8; i++) begin
            if (credits_o == 3'd4) break;
            pipe_retire_i = 1'b1;
            tick();
        end
        pipe_retire_i = 1'b0;
        n_vec++;
        if (credits_o !== 3'd4) begin
            n_err++;
            $display("FAIL drain_credits got=%0d exp=4", credits_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        clear_inputs();
        rf_valid_i = 1'b1; wb_valid_i = 1'b1; core_valid_i = 1'b1;
        repeat (2) tick();
        n_vec++;
        if ({pipe_valid_o, pipe_op_o, pipe_src_o, pipe_id_o} !== 10'd0 || pipe_addr_o !== '0) begin
            n_err++;
            $display("FAIL reset_outputs valid=%0b op=%0d src=%0d id=%0d addr=%0h exp all 0",
                     pipe_valid_o, pipe_op_o, pipe_src_o, pipe_id_o, pipe_addr_o);
        end
        n_vec++;
        if (credits_o !== 3'd4 || err_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_credits_err credits=%0d err=%0b exp 4/0", credits_o, err_o);
        end
        n_vec++;
        if ({rf_ready_o, wb_ready_o, core_ready_o} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_no_grant rf/wb/core ready=%03b exp 000",
                     {rf_ready_o, wb_ready_o, core_ready_o});
        end
        clear_inputs();
        rst_i = 1'b0;
        tick();
        n_vec++;
        if (pipe_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle valid=%0b exp 0", pipe_valid_o);
        end
    endtask

    task automatic test_priority();
        rf_valid_i = 1'b1; rf_op_i = 3'd5; rf_addr_i = 49'h40; rf_id_i = 4'd1;
        wb_valid_i = 1'b1; wb_addr_i = 49'h80; wb_id_i = 4'd2;
        core_valid_i = 1'b1; core_op_i = 3'd0; core_addr_i = 49'hC0; core_id_i = 4'd3;
        #1;
        n_vec++;
        if ({rf_ready_o, wb_ready_o, core_ready_o} !== 3'b100) begin
            n_err++;
            $display("FAIL prio_rf_first ready=%03b exp 100", {rf_ready_o, wb_ready_o, core_ready_o});
        end
        tick();
        rf_valid_i = 1'b0;
        #1;
        n_vec++;
        if ({pipe_valid_o, pipe_src_o, pipe_op_o, pipe_id_o} !== {1'b1, 2'd2, 3'd5, 4'd1} || pipe_addr_o !== 49'h40) begin
            n_err++;
            $display("FAIL prio_rf_issue v=%0b src=%0d op=%0d id=%0d addr=%0h exp 1/2/5/1/40",
                     pipe_valid_o, pipe_src_o, pipe_op_o, pipe_id_o, pipe_addr_o);
        end
        n_vec++;
        if ({rf_ready_o, wb_ready_o, core_ready_o} !== 3'b010) begin
            n_err++;
            $display("FAIL prio_wb_second ready=%03b exp 010", {rf_ready_o, wb_ready_o, core_ready_o});
        end
        tick();
        wb_valid_i = 1'b0;
        #1;
        n_vec++;
        if ({pipe_src_o, pipe_op_o, pipe_id_o} !== {2'd1, 3'd4, 4'd2} || pipe_addr_o !== 49'h80) begin
            n_err++;
            $display("FAIL prio_wb_issue src=%0d op=%0d id=%0d addr=%0h exp 1/4/2/80",
                     pipe_src_o, pipe_op_o, pipe_id_o, pipe_addr_o);
        end
        n_vec++;
        if (core_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL prio_core_third core_ready=%0b exp 1", core_ready_o);
        end
        tick();
        core_valid_i = 1'b0;
        #1;
        n_vec++;
        if ({pipe_src_o, pipe_op_o, pipe_id_o, credits_o} !== {2'd0, 3'd0, 4'd3, 3'd1} || pipe_addr_o !== 49'hC0) begin
            n_err++;
            $display("FAIL prio_core_issue src=%0d op=%0d id=%0d credits=%0d exp 0/0/3/1",
                     pipe_src_o, pipe_op_o, pipe_id_o, credits_o);
        end
        tick();
        n_vec++;
        if (pipe_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL prio_valid_clears valid=%0b exp 0", pipe_valid_o);
        end
        drain();
    endtask

    task automatic test_credits();
        core_valid_i = 1'b1; core_op_i = 3'd0; core_addr_i = 49'h100; core_id_i = 4'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++;
            if (core_ready_o !== 1'b1) begin
                n_err++;
                $display("FAIL credit_grant_%0d core_ready=%0b exp 1", i, core_ready_o);
            end
            tick();
            core_id_i   = 4'(i + 1);
            core_addr_i = 49'h100 + 49'(i + 1) * 49'h40;
        end
        #1;
        n_vec++;
        if (credits_o !== 3'd0 || core_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL credit_exhausted credits=%0d core_ready=%0b exp 0/0", credits_o, core_ready_o);
        end
        tick();
        pipe_retire_i = 1'b1;
        #1;
        n_vec++;
        if (core_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL credit_retire_same_cycle core_ready=%0b exp 0", core_ready_o);
        end
        tick();
        pipe_retire_i = 1'b0;
        #1;
        n_vec++;
        if (credits_o !== 3'd1 || core_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL credit_retire_next_cycle credits=%0d core_ready=%0b exp 1/1", credits_o, core_ready_o);
        end
        tick();
        core_valid_i = 1'b0;
        #1;
        n_vec++;
        if (pipe_addr_o !== 49'h200 || pipe_id_o !== 4'd4 || credits_o !== 3'd0) begin
            n_err++;
            $display("FAIL credit_fifth_issue addr=%0h id=%0d credits=%0d exp 200/4/0",
                     pipe_addr_o, pipe_id_o, credits_o);
        end
        drain();
    endtask

    task automatic test_starve();
        wb_valid_i = 1'b1; wb_addr_i = 49'h300; wb_id_i = 4'd5;
        core_valid_i = 1'b1; core_op_i = 3'd0; core_addr_i = 49'h400; core_id_i = 4'd6;
        for (int i = 0; i < 9; i++) begin
            pipe_retire_i = (credits_o != 3'd4);
            #1;
            n_vec++;
            if (core_ready_o !== (i == 8) || wb_ready_o !== (i != 8)) begin
                n_err++;
                $display("FAIL starve_cycle_%0d core_ready=%0b wb_ready=%0b", i, core_ready_o, wb_ready_o);
            end
            tick();
        end
        core_valid_i  = 1'b0;
        pipe_retire_i = (credits_o != 3'd4);
        #1;
        n_vec++;
        if (pipe_src_o !== 2'd0 || pipe_id_o !== 4'd6 || wb_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL starve_core_issue src=%0d id=%0d wb_ready=%0b exp 0/6/1",
                     pipe_src_o, pipe_id_o, wb_ready_o);
        end
        tick();
        wb_valid_i = 1'b0;
        #1;
        n_vec++;
        if (pipe_src_o !== 2'd1 || err_o !== 1'b0) begin
            n_err++;
            $display("FAIL starve_wb_resumes src=%0d err=%0b exp 1/0", pipe_src_o, err_o);
        end
        drain();
    endtask

    task automatic test_stall();
        core_valid_i = 1'b1; core_op_i = 3'd1; core_addr_i = 49'h1000; core_id_i = 4'd3;
        #1;
        n_vec++;
        if (core_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL stall_core_grant core_ready=%0b exp 1", core_ready_o);
        end
        tick();
        core_valid_i = 1'b0;
        pipe_ready_i = 1'b0;
        rf_valid_i = 1'b1; rf_op_i = 3'd6; rf_addr_i = 49'h2000; rf_id_i = 4'd7;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++;
            if ({pipe_valid_o, pipe_op_o, pipe_id_o, rf_ready_o} !== {1'b1, 3'd1, 4'd3, 1'b0} || pipe_addr_o !== 49'h1000) begin
                n_err++;
                $display("FAIL stall_hold_%0d v=%0b op=%0d addr=%0h id=%0d rf_ready=%0b exp 1/1/1000/3/0",
                         i, pipe_valid_o, pipe_op_o, pipe_addr_o, pipe_id_o, rf_ready_o);
            end
            tick();
        end
        pipe_ready_i = 1'b1;
        #1;
        n_vec++;
        if (rf_ready_o !== 1'b1 || pipe_op_o !== 3'd1) begin
            n_err++;
            $display("FAIL stall_accept rf_ready=%0b op=%0d exp 1/1", rf_ready_o, pipe_op_o);
        end
        tick();
        rf_valid_i = 1'b0;
        #1;
        n_vec++;
        if (pipe_src_o !== 2'd2 || pipe_op_o !== 3'd6 || pipe_addr_o !== 49'h2000) begin
            n_err++;
            $display("FAIL stall_next_issue src=%0d op=%0d addr=%0h exp 2/6/2000", pipe_src_o, pipe_op_o, pipe_addr_o);
        end
        tick();
        drain();
    endtask

    task automatic test_err();
        n_vec++;
        if (err_o !== 1'b0) begin
            n_err++;
            $display("FAIL err_initial err=%0b exp 0", err_o);
        end
        pipe_retire_i = 1'b1;
        tick();
        pipe_retire_i = 1'b0;
        n_vec++;
        if (err_o !== 1'b1 || credits_o !== 3'd4) begin
            n_err++;
            $display("FAIL err_bad_retire err=%0b credits=%0d exp 1/4", err_o, credits_o);
        end
        repeat (3) tick();
        n_vec++;
        if (err_o !== 1'b1) begin
            n_err++;
            $display("FAIL err_sticky err=%0b exp 1", err_o);
        end
        apply_reset();
        n_vec++;
        if (err_o !== 1'b0) begin
            n_err++;
            $display("FAIL err_reset_clear err=%0b exp 0", err_o);
        end
        core_valid_i = 1'b1; core_op_i = 3'd3; core_addr_i = 49'h500; core_id_i = 4'd9;
        #1;
        n_vec++;
        if (core_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL err_illegal_grant core_ready=%0b exp 1", core_ready_o);
        end
        tick();
        core_valid_i = 1'b0;
        #1;
        n_vec++;
        if ({pipe_valid_o, pipe_op_o, pipe_id_o, err_o} !== {1'b1, 3'd0, 4'd9, 1'b1}) begin
            n_err++;
            $display("FAIL err_illegal_issue v=%0b op=%0d id=%0d err=%0b exp 1/0/9/1",
                     pipe_valid_o, pipe_op_o, pipe_id_o, err_o);
        end
        tick();
        drain();
    endtask

    task automatic test_async_reset();
        core_valid_i = 1'b1; core_op_i = 3'd0; core_addr_i = 49'h600; core_id_i = 4'd1;
        repeat (3) tick();
        core_valid_i = 1'b0;
        pipe_ready_i = 1'b0;
        #1;
        n_vec++;
        if (pipe_valid_o !== 1'b1 || credits_o !== 3'd1 || err_o !== 1'b1) begin
            n_err++;
            $display("FAIL async_setup v=%0b credits=%0d err=%0b exp 1/1/1", pipe_valid_o, credits_o, err_o);
        end
        #1;
        rst_i = 1'b1;
        #1;
        n_vec++;
        if (pipe_valid_o !== 1'b0 || credits_o !== 3'd4 || err_o !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset v=%0b credits=%0d err=%0b exp 0/4/0", pipe_valid_o, credits_o, err_o);
        end
        tick();
        rst_i = 1'b0;
        clear_inputs();
        tick();
    endtask

    initial begin
        rst_i = 1'b1;
        clear_inputs();
        test_reset();
        test_priority();
        test_credits();
        test_starve();
        test_stall();
        test_err();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
